// File: rtl/apb_timer_pkg.sv
// Shared constants for the multi-channel APB timer: register offsets,
// CTRL field positions, the unmapped-read pattern and the CTRL readback packer.
package apb_timer_pkg;

  localparam logic [3:0]  REG_LOAD    = 4'h0;
  localparam logic [3:0]  REG_VALUE   = 4'h4;
  localparam logic [3:0]  REG_CTRL    = 4'h8;
  localparam logic [3:0]  REG_STATUS  = 4'hC;
  localparam logic [7:0]  IRQSTAT_OFF = 8'h80;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_MODE_BIT  = 1;
  localparam int CTRL_IRQEN_BIT = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  localparam logic [31:0] DEFAULT_RDATA = 32'hDEADBEEF;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_RELOAD  = 1'b1
  } mode_e;

  function automatic logic [31:0] ctrl_pack(input logic en, input mode_e mode,
                                            input logic irq_en, input logic [7:0] presc);
    logic [31:0] r;
    r = '0;
    r[CTRL_EN_BIT]                   = en;
    r[CTRL_MODE_BIT]                 = (mode == MODE_RELOAD);
    r[CTRL_IRQEN_BIT]                = irq_en;
    r[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = presc;
    return r;
  endfunction

endpackage

// File: rtl/apb_timer_mc_if.sv
// APB bus bundle between the host and the timer block.
interface apb_timer_mc_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_timer_ch.sv
// One timer channel: LOAD/CTRL registers, prescale divider, counter and sticky flag.
module apb_timer_ch
  import apb_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             load_we,
  input  logic             ctrl_we,
  input  logic             status_clr,
  input  logic [31:0]      wdata,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] value,
  output logic [31:0]      ctrl_rd,
  output logic             flag,
  output logic             irq
);

  logic             en;
  logic             irq_en;
  mode_e            mode;
  logic [7:0]       presc;
  logic [7:0]       div_q, div_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  logic             tick;
  logic             hit;

  assign tick    = en && (div_q == presc);
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    cnt_n = cnt_q;
    div_n = div_q;
    hit   = 1'b0;
    if (!en) begin
      cnt_n = '0;
      div_n = '0;
    end else begin
      div_n = tick ? 8'd0 : div_q + 8'd1;
      if (tick) begin
        if (mode == MODE_RELOAD) begin
          if (cnt_q >= load) begin
            cnt_n = '0;
            hit   = 1'b1;
          end else begin
            cnt_n = cnt_inc;
          end
        end else if (cnt_q < load) begin
          // one-shot stops at LOAD; a counter already past a lowered LOAD just holds
          cnt_n = cnt_inc;
          hit   = (cnt_inc == load);
        end
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      load   <= '0;
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      irq_en <= 1'b0;
      presc  <= '0;
      cnt_q  <= '0;
      div_q  <= '0;
      flag   <= 1'b0;
    end else begin
      if (load_we) load <= wdata[CNT_W-1:0];
      if (ctrl_we) begin
        en     <= wdata[CTRL_EN_BIT];
        mode   <= mode_e'(wdata[CTRL_MODE_BIT]);
        irq_en <= wdata[CTRL_IRQEN_BIT];
        presc  <= wdata[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
      end
      cnt_q <= cnt_n;
      div_q <= div_n;
      // hardware set beats a simultaneous write-1-clear
      flag  <= hit | (flag & ~status_clr);
    end
  end

  assign value   = cnt_q;
  assign ctrl_rd = ctrl_pack(en, mode, irq_en, presc);
  assign irq     = flag & irq_en;

  logic unused_wdata;
  assign unused_wdata = ^{wdata[31:16], wdata[7:3]};

endmodule

// File: rtl/apb_timer_mc.sv
// Multi-channel APB timer: address decode, write strobes, registered read mux
// and the per-channel timer array.
module apb_timer_mc
  import apb_timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) (
  input  logic              pclk,
  input  logic              presetn,
  apb_timer_mc_if.slave     apb,
  output logic [NUM_CH-1:0] irq,
  output logic              irq_any
);

  logic [3:0]       ch_sel;
  logic [3:0]       reg_off;
  logic             ch_hit, is_irqstat, mapped;
  logic             wr_p0;
  logic [31:0]      rdata_p0;
  logic [31:0]      prdata_p1;
  logic [CNT_W-1:0] load_q  [NUM_CH];
  logic [CNT_W-1:0] value_q [NUM_CH];
  logic [31:0]      ctrl_q  [NUM_CH];
  logic [NUM_CH-1:0] flag_q;

  assign ch_sel     = apb.paddr[7:4];
  assign reg_off    = {apb.paddr[3:2], 2'b00};
  assign ch_hit     = (ch_sel < 4'(NUM_CH));
  assign is_irqstat = (apb.paddr[7:2] == IRQSTAT_OFF[7:2]);
  assign mapped     = ch_hit | is_irqstat;
  assign wr_p0      = apb.psel && apb.pwrite && apb.penable && ch_hit;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic sel;
    assign sel = wr_p0 && (ch_sel == 4'(n));
    apb_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .pclk       (pclk),
      .presetn    (presetn),
      .load_we    (sel && (reg_off == REG_LOAD)),
      .ctrl_we    (sel && (reg_off == REG_CTRL)),
      .status_clr (sel && (reg_off == REG_STATUS) && apb.pwdata[0]),
      .wdata      (apb.pwdata),
      .load       (load_q[n]),
      .value      (value_q[n]),
      .ctrl_rd    (ctrl_q[n]),
      .flag       (flag_q[n]),
      .irq        (irq[n])
    );
  end

  assign irq_any = |irq;

  always_comb begin
    rdata_p0 = DEFAULT_RDATA;
    if (is_irqstat) begin
      rdata_p0 = 32'(irq);
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (ch_hit && (ch_sel == 4'(n))) begin
          case (reg_off)
            REG_LOAD:   rdata_p0 = 32'(load_q[n]);
            REG_VALUE:  rdata_p0 = 32'(value_q[n]);
            REG_CTRL:   rdata_p0 = ctrl_q[n];
            default:    rdata_p0 = {31'b0, flag_q[n]};
          endcase
        end
      end
    end
  end

  // read data captured in setup, held through access, zero otherwise
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      prdata_p1 <= '0;
    end else if (apb.psel && !apb.pwrite && !apb.penable) begin
      prdata_p1 <= rdata_p0;
    end else if (apb.psel && !apb.pwrite && apb.penable) begin
      prdata_p1 <= prdata_p1;
    end else begin
      prdata_p1 <= '0;
    end
  end

  assign apb.prdata  = prdata_p1;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel && apb.penable && !mapped;

  logic unused_paddr;
  assign unused_paddr = ^{apb.paddr[15:8], apb.paddr[1:0]};

endmodule

// File: tb/tb_apb_timer_mc.sv
// Directed self-checking bench for apb_timer_mc (NUM_CH=4, CNT_W=32).
module tb_apb_timer_mc;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic              pclk = 1'b0;
  logic              presetn = 1'b0;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
  int                checks = 0;
  int                errors = 0;

  apb_timer_mc_if bus ();

  apb_timer_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .apb     (bus),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 pclk = ~pclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before 100000 ns");
    $fatal(1);
  end

  // Both tasks start at posedge+1; write commits on the second edge, read captures on the first.
  task automatic apb_write(input logic [15:0] a, input logic [31:0] d, output logic err);
    bus.psel = 1'b1; bus.pwrite = 1'b1; bus.penable = 1'b0; bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1 bus.penable = 1'b1;
    #1 err = bus.pslverr;
    @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [15:0] a, output logic [31:0] d, output logic err);
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.penable = 1'b0; bus.paddr = a;
    @(posedge pclk); #1 bus.penable = 1'b1;
    #1 d = bus.prdata; err = bus.pslverr;
    @(posedge pclk); #1 bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
    presetn = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    checks++; if (irq !== 4'h0 || irq_any !== 1'b0) begin errors++; $display("FAIL reset_irq: got %h/%b required 0/0", irq, irq_any); end
    checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h required 0", bus.prdata); end
    checks++; if (bus.pready !== 1'b1) begin errors++; $display("FAIL pready: got %b required 1", bus.pready); end
    presetn = 1'b1;
    @(posedge pclk); #1;
    apb_read(16'h0008, d, e);
    checks++; if (d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL reset_ctrl0: got %h err %b required 0 err 0", d, e); end
    apb_read(16'h0030, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_load3: got %h required 0", d); end
  endtask

  task automatic test_ctrl_fields();
    logic [31:0] d; logic e;
    apb_write(16'h0038, 32'hFFFF_FFF8, e);
    apb_read(16'h0038, d, e);
    checks++; if (d !== 32'h0000_FF00) begin errors++; $display("FAIL ctrl_mask: got %h required 0000ff00", d); end
    apb_write(16'h0038, 32'h0, e);
    apb_write(16'h0030, 32'hA5A5_5A5A, e);
    apb_read(16'h0030, d, e);
    checks++; if (d !== 32'hA5A5_5A5A) begin errors++; $display("FAIL load_rw: got %h required a5a55a5a", d); end
    apb_write(16'h0030, 32'h0, e);
  endtask

  task automatic test_oneshot();
    logic [31:0] d; logic e;
    apb_write(16'h0000, 32'd5, e);
    apb_write(16'h0008, 32'h1, e);
    repeat (4) @(posedge pclk);
    #1;
    apb_read(16'h0004, d, e);
    checks++; if (d !== 32'd4) begin errors++; $display("FAIL oneshot_cnt4: got %0d required 4", d); end
    apb_read(16'h0004, d, e);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL oneshot_cnt5: got %0d required 5", d); end
    repeat (6) @(posedge pclk);
    #1;
    apb_read(16'h0004, d, e);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL oneshot_hold: got %0d required 5", d); end
    apb_read(16'h000C, d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL oneshot_flag: got %h required 1", d); end
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL oneshot_irq_masked: got %b required 0", irq[0]); end
    apb_write(16'h0008, 32'h0, e);
    @(posedge pclk); #1;
    apb_read(16'h0004, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL disable_clears_cnt: got %0d required 0", d); end
    apb_read(16'h000C, d, e);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL disable_keeps_flag: got %h required 1", d); end
  endtask

  task automatic test_reload_w1c();
    logic [31:0] d; logic e;
    apb_write(16'h0010, 32'd3, e);
    apb_write(16'h0018, 32'h0207, e);
    repeat (11) @(posedge pclk);
    #1;
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL reload_before_wrap: got %b required 0", irq[1]); end
    @(posedge pclk); #1;
    checks++; if (irq[1] !== 1'b1 || irq_any !== 1'b1) begin errors++; $display("FAIL reload_wrap_irq: got %b/%b required 1/1", irq[1], irq_any); end
    apb_read(16'h0080, d, e);
    checks++; if (d !== 32'h2 || e !== 1'b0) begin errors++; $display("FAIL irqstat: got %h err %b required 2 err 0", d, e); end
    apb_write(16'h001C, 32'h1, e);
    checks++; if (irq[1] !== 1'b0 || irq_any !== 1'b0) begin errors++; $display("FAIL w1c_clear: got %b/%b required 0/0", irq[1], irq_any); end
    repeat (6) @(posedge pclk);
    #1;
    apb_write(16'h001C, 32'h1, e);
    checks++; if (irq[1] !== 1'b1) begin errors++; $display("FAIL w1c_collision: got %b required 1", irq[1]); end
    apb_write(16'h001C, 32'h1, e);
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL w1c_after_collision: got %b required 0", irq[1]); end
    apb_read(16'h0014, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reload_value_after_wrap: got %0d required 0", d); end
    apb_write(16'h0018, 32'h0, e);
    @(posedge pclk); #1;
    apb_read(16'h0014, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reload_disable_cnt: got %0d required 0", d); end
  endtask

  task automatic test_reload_zero();
    logic [31:0] d; logic e;
    apb_write(16'h0028, 32'h7, e);
    @(posedge pclk); #1;
    checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL load0_first_tick: got %b required 1", irq[2]); end
    apb_write(16'h002C, 32'h1, e);
    checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL load0_every_tick: got %b required 1", irq[2]); end
    apb_write(16'h0020, 32'd10, e);
    apb_write(16'h002C, 32'h1, e);
    checks++; if (irq[2] !== 1'b0) begin errors++; $display("FAIL load10_cleared: got %b required 0", irq[2]); end
    repeat (8) @(posedge pclk);
    #1;
    checks++; if (irq[2] !== 1'b0) begin errors++; $display("FAIL load10_tick10: got %b required 0", irq[2]); end
    @(posedge pclk); #1;
    checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL load10_tick11: got %b required 1", irq[2]); end
  endtask

  task automatic test_oneshot_edges();
    logic [31:0] d; logic e;
    apb_write(16'h0030, 32'd8, e);
    apb_write(16'h0038, 32'h5, e);
    repeat (4) @(posedge pclk);
    #1;
    apb_write(16'h0030, 32'd3, e);
    apb_read(16'h0034, d, e);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL lowered_load_hold: got %0d required 6", d); end
    repeat (3) @(posedge pclk);
    #1;
    apb_read(16'h0034, d, e);
    checks++; if (d !== 32'd6) begin errors++; $display("FAIL lowered_load_still: got %0d required 6", d); end
    apb_read(16'h003C, d, e);
    checks++; if (d !== 32'h0 || irq[3] !== 1'b0) begin errors++; $display("FAIL lowered_load_noflag: got %h irq %b required 0 irq 0", d, irq[3]); end
    apb_write(16'h0038, 32'h0, e);
    apb_write(16'h0030, 32'h0, e);
    apb_write(16'h0038, 32'h5, e);
    repeat (5) @(posedge pclk);
    #1;
    checks++; if (irq[3] !== 1'b0) begin errors++; $display("FAIL oneshot_load0_irq: got %b required 0", irq[3]); end
    apb_read(16'h003C, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL oneshot_load0_flag: got %h required 0", d); end
    apb_write(16'h0038, 32'h0, e);
  endtask

  task automatic test_unmapped();
    logic [31:0] d; logic e;
    apb_read(16'h0070, d, e);
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b1) begin errors++; $display("FAIL unmapped_read70: got %h err %b required deadbeef err 1", d, e); end
    @(posedge pclk); #1;
    checks++; if (bus.prdata !== 32'h0) begin errors++; $display("FAIL prdata_idle: got %h required 0", bus.prdata); end
    apb_read(16'h0040, d, e);
    checks++; if (d !== 32'hDEADBEEF || e !== 1'b1) begin errors++; $display("FAIL unmapped_read40: got %h err %b required deadbeef err 1", d, e); end
    apb_write(16'h0070, 32'hFFFF_FFFF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL unmapped_write_err: got %b required 1", e); end
    apb_write(16'h0040, 32'hFFFF_FFFF, e);
    apb_read(16'h0000, d, e);
    checks++; if (d !== 32'd5) begin errors++; $display("FAIL unmapped_no_effect_load0: got %h required 5", d); end
    apb_read(16'h0030, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_no_effect_load3: got %h required 0", d); end
    apb_read(16'h0038, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_no_effect_ctrl3: got %h required 0", d); end
  endtask

  task automatic test_midcount_reset();
    logic [31:0] d; logic e;
    checks++; if (irq[2] !== 1'b1) begin errors++; $display("FAIL pre_reset_irq2: got %b required 1", irq[2]); end
    presetn = 1'b0;
    @(posedge pclk); #1 presetn = 1'b1;
    checks++; if (irq !== 4'h0 || irq_any !== 1'b0 || bus.prdata !== 32'h0) begin errors++; $display("FAIL midreset_outputs: got %h/%b/%h required 0/0/0", irq, irq_any, bus.prdata); end
    apb_read(16'h0028, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_ctrl2: got %h required 0", d); end
    apb_read(16'h0020, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_load2: got %h required 0", d); end
    apb_read(16'h0024, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_value2: got %h required 0", d); end
    apb_read(16'h002C, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status2: got %h required 0", d); end
    apb_read(16'h000C, d, e);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status0: got %h required 0", d); end
    apb_read(16'h0080, d, e);
    checks++; if (d !== 32'h0 || irq !== 4'h0) begin errors++; $display("FAIL midreset_irqstat: got %h irq %h required 0 irq 0", d, irq); end
  endtask

  initial begin
    test_reset();
    test_ctrl_fields();
    test_oneshot();
    test_reload_w1c();
    test_reload_zero();
    test_oneshot_edges();
    test_unmapped();
    test_midcount_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer_mc.md
APB_TIMER_MC -- requirements
Module: apb_timer_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent timer channels; legal values 1..8.
REQ-002 Parameter CNT_W, default 32, counter and load width; legal values 8..32.
REQ-003 pclk  input  1  the only clock; all state updates on its rising edge.
REQ-004 presetn  input  1  reset, synchronous and active-low.
REQ-005 psel, penable, pwrite  input  1 each  APB control signals.
REQ-006 paddr  input  16  byte address; only paddr[7:2] is decoded.
REQ-007 pwdata  input  32  write data.
REQ-008 prdata  output  32  registered read data.
REQ-009 pready  output  1  tied high; no wait states.
REQ-010 pslverr  output  1  high during an access phase to an unmapped address.
REQ-011 irq  output  NUM_CH  per-channel interrupt, equal to STATUS.flag AND CTRL.irq_en.
REQ-012 irq_any  output  1  OR-reduction of irq.

Function
REQ-013 Register map: channel n occupies offsets n*0x10 + {0x0 LOAD rw, 0x4 VALUE ro, 0x8 CTRL rw, 0xC STATUS w1c}; offset 0x80 is IRQSTAT ro (irq vector, zero-extended).
REQ-014 CTRL fields: bit0 en, bit1 mode (0 one-shot, 1 reload), bit2 irq_en, bits[15:8] presc; all other bits read 0.
REQ-015 A write commits when psel && pwrite && penable; LOAD takes pwdata[CNT_W-1:0].
REQ-016 A read is captured into prdata in the setup phase (psel && !pwrite && !penable) and held through the access phase; prdata is 0 in all other cycles.
REQ-017 Reads of unmapped offsets, including channels >= NUM_CH, return 32'hDEADBEEF; writes to them are ignored and pslverr is asserted in the access phase.
REQ-018 LOAD and VALUE read back zero-extended to 32 bits.
REQ-019 Prescaler: with en=1, the per-channel 8-bit divider produces one tick every presc+1 pclk cycles; presc=0 ticks every cycle.
REQ-020 One-shot mode: on a tick, if counter < LOAD then counter increments, and the flag sets when the new value equals LOAD; at counter == LOAD the counter holds.
REQ-021 Reload mode: on a tick, if counter >= LOAD then counter becomes 0 and the flag sets; otherwise counter increments. The period is LOAD+1 ticks.
REQ-022 With en=0, the counter and divider are held at 0 and no flag is set.
REQ-023 A LOAD write while running takes effect on the next tick with no counter reset; in one-shot mode a counter above the new LOAD holds with no event.
REQ-024 One-shot mode with LOAD=0 never sets the flag; reload mode with LOAD=0 sets the flag on every tick.
REQ-025 Writing STATUS bit0=1 clears the flag; a hardware set in the same cycle wins.
REQ-026 A CTRL write taking en from 1 to 0 clears the counter and divider in the next cycle; the flag is unaffected.
REQ-027 Arithmetic is CNT_W-bit unsigned; the counter never wraps by overflow.

Reset
REQ-028 When presetn=0 at a pclk edge, all LOAD, CTRL, STATUS, counter and divider registers reset to 0, prdata resets to 0, and consequently irq and irq_any are 0.
REQ-029 Reset asserted mid-count aborts the count with no residual flag or interrupt.

Structure
REQ-030 Package apb_timer_pkg holds the register offset constants, CTRL field bit positions, and the 32'hDEADBEEF default.
REQ-031 Sub-module apb_timer_ch (divider, counter, flag) is instantiated NUM_CH times by generate; apb_timer_mc holds APB decode and the read mux.

Verification
REQ-032 Ch0: LOAD=5, CTRL=0x1 (one-shot, presc=0) -> VALUE reaches 5 after 5 cycles and holds; flag sets once; irq[0]=0 because irq_en=0.
REQ-033 Ch1: LOAD=3, CTRL=0x0207 (reload, irq_en, presc=2) -> counter wraps every 12 cycles; irq[1] and irq_any go high; writing STATUS=1 clears them.
REQ-034 Same-cycle STATUS write-1-clear and a wrap event -> flag remains 1.
REQ-035 Read offset 0x70 with NUM_CH=4 -> prdata=0xDEADBEEF and pslverr=1 in the access phase; a write there changes no state.
REQ-036 Reload mode LOAD=0 -> flag sets every tick; then LOAD=10 written while running at counter 0 -> next flag 11 ticks later.
REQ-037 presetn low for 1 cycle mid-count -> all registers read 0 and irq=0 on the next cycle.
